// File: rtl/serial_pattern_pkg.sv
// Shared types and defaults for the serial frame generator and the detectors it feeds.
// Provides the state enum, the default sync header and a small sizing helper.
package serial_pattern_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        DATA,
        PARITY,
        GAP
    } state_e;

    localparam int DEF_SYNC_LEN = 4;
    localparam logic [DEF_SYNC_LEN-1:0] DEF_SYNC_PAT = 4'b1010;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/serial_pattern_gen_piso.sv
// Parallel-load, MSB-first shift register; load wins over shift.
// Ports: clk, rst_n (async low), load_i, shift_i, d_i[W], msb_o.
module piso_shift #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         shift_i,
    input  logic [W-1:0] d_i,
    output logic         msb_o
);

    logic [W-1:0] sr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else if (load_i) begin
            sr_q <= d_i;
        end else if (shift_i) begin
            sr_q <= sr_q << 1;
        end
    end

    assign msb_o = sr_q[W-1];

endmodule

// File: rtl/serial_pattern_gen.sv
// Serial frame transmitter: sync header, payload MSB-first, optional parity, idle gap.
// Ports: clk, reset (async low), in_data/in_valid/in_ready handshake,
// out_bit/out_valid/frame_done (registered), busy. Macro SERIAL_PATTERN_PARITY_EN adds parity.
module serial_pattern_gen
    import serial_pattern_pkg::*;
#(
    parameter int                  DATA_W     = 8,
    parameter int                  SYNC_LEN   = DEF_SYNC_LEN,
    parameter logic [SYNC_LEN-1:0] SYNC_PAT   = DEF_SYNC_PAT,
    parameter int                  GAP_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out_bit,
    output logic              out_valid,
    output logic              frame_done,
    output logic              busy
);

    localparam int CW = $clog2(max3(SYNC_LEN, DATA_W, GAP_CYCLES)) + 1;
    localparam logic [CW-1:0] SL_C   = CW'(SYNC_LEN);
    localparam logic [CW-1:0] DL_C   = CW'(DATA_W - 1);
    localparam logic [CW-1:0] GAP_C  = CW'(GAP_CYCLES);
    localparam state_e POST_FRAME = state_e'((GAP_CYCLES > 0) ? GAP : IDLE);
`ifdef SERIAL_PATTERN_PARITY_EN
    localparam state_e POST_DATA = PARITY;
    localparam bit LAST_ON_DATA = 1'b0;
`else
    localparam state_e POST_DATA = POST_FRAME;
    localparam bit LAST_ON_DATA = 1'b1;
`endif

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          out_bit_q, out_bit_d;
    logic          out_valid_q, out_valid_d;
    logic          frame_done_q, frame_done_d;
    logic          load, shift, data_msb;
    logic          accept, sync_end, data_end;
    logic [SYNC_LEN-1:0] sync_sh;

    // Held in reset the block must not advertise readiness.
    assign in_ready = reset && (state_q == IDLE);
    assign busy     = !in_ready;
    assign accept   = in_valid && in_ready;
    assign sync_end = (cnt_q == SL_C);
    assign data_end = (cnt_q == DL_C);
    assign sync_sh  = SYNC_PAT << cnt_q;

    piso_shift #(.W(DATA_W)) u_piso (
        .clk     (clk),
        .rst_n   (reset),
        .load_i  (load),
        .shift_i (shift),
        .d_i     (in_data),
        .msb_o   (data_msb)
    );

`ifdef SERIAL_PATTERN_PARITY_EN
    logic par_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            par_q <= 1'b0;
        end else if (accept) begin
            par_q <= ^in_data;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            out_bit_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            out_bit_q    <= out_bit_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    // cnt_q: sync bits sent in SYNC, data bits sent in DATA, gap cycles in GAP.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        shift   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SYNC;
                    cnt_d   = CW'(1);
                    load    = 1'b1;
                end
            end
            SYNC: begin
                if (sync_end) begin
                    shift = 1'b1;
                    if (DATA_W == 1) begin
                        state_d = POST_DATA;
                        cnt_d   = '0;
                    end else begin
                        state_d = DATA;
                        cnt_d   = CW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                shift = 1'b1;
                if (data_end) begin
                    state_d = POST_DATA;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef SERIAL_PATTERN_PARITY_EN
            PARITY: begin
                state_d = POST_FRAME;
                cnt_d   = '0;
            end
`endif
            GAP: begin
                if (cnt_q == GAP_C) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        out_bit_d    = 1'b0;
        out_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    out_bit_d   = SYNC_PAT[SYNC_LEN-1];
                    out_valid_d = 1'b1;
                end
            end
            SYNC: begin
                out_valid_d  = 1'b1;
                out_bit_d    = sync_end ? data_msb : sync_sh[SYNC_LEN-1];
                frame_done_d = LAST_ON_DATA && sync_end && (DATA_W == 1);
            end
            DATA: begin
                out_valid_d  = 1'b1;
                out_bit_d    = data_msb;
                frame_done_d = LAST_ON_DATA && data_end;
            end
`ifdef SERIAL_PATTERN_PARITY_EN
            PARITY: begin
                out_valid_d  = 1'b1;
                out_bit_d    = par_q;
                frame_done_d = 1'b1;
            end
`endif
            default: begin
            end
        endcase
    end

    assign out_bit    = out_bit_q;
    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;

endmodule

// File: doc/serial_pattern_gen.md
Name: serial_pattern_gen

Overview:
- Serial frame transmitter that feeds the team's Moore-style serial pattern detectors.
- Accepts a parallel data word over a valid/ready handshake.
- Emits one bit per clock: a fixed sync header (default 1010), then the data word MSB-first, then an idle gap of zeros.
- Sits upstream of the detector/receiver on the single-bit serial link.

Parameters:
- DATA_W, 8, payload width in bits (≥1).
- SYNC_LEN, 4, sync header length in bits (≥1).
- SYNC_PAT, 4'b1010, sync header value, sent MSB-first (width SYNC_LEN).
- GAP_CYCLES, 2, idle cycles forced after each frame (≥0).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- in_data  in  DATA_W  payload word.
- in_valid  in  1  payload offered.
- in_ready  out  1  block can accept a word this cycle.
- out_bit  out  1  serial bit, registered.
- out_valid  out  1  out_bit carries a frame bit (sync, data or parity), registered.
- frame_done  out  1  one-cycle pulse, registered.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; out_bit=0, out_valid=0, frame_done=0.
  - Shift register and counters cleared.
  - Reset mid-frame aborts the frame immediately; no partial resumption.
- States: IDLE, SYNC, DATA, (PARITY), GAP.
- in_ready = (state==IDLE), combinational from state; busy = !in_ready.
- Accept: on a rising edge with in_valid && in_ready.
  - Capture in_data and go to SYNC.
  - On the same edge: out_bit<=SYNC_PAT[SYNC_LEN-1], out_valid<=1.
  - First bit is visible the cycle after accept (latency 1).
- SYNC: each edge emits the next SYNC_PAT bit. After SYNC_LEN bits, emit in_data[DATA_W-1] and go to DATA.
- DATA: each edge emits the next lower data bit. The edge emitting bit 0 also sets frame_done<=1 for exactly that displayed cycle. Next state:
  - PARITY if enabled;
  - else GAP if GAP_CYCLES>0;
  - else IDLE.
- GAP: out_bit=0, out_valid=0 for GAP_CYCLES cycles, then IDLE.
- Back-to-back frames with GAP_CYCLES=0:
  - in_ready is high during the last-bit cycle.
  - If a word is accepted then, the next frame's first sync bit follows with no bubble.
- in_valid while busy is ignored; in_data is sampled only on the accept edge. Later changes to in_data do not affect the frame in flight.
- Frame length = SYNC_LEN+DATA_W (+1 with parity) valid bits. out_valid is continuous across the whole frame.
- Counters sized $clog2 of the max of SYNC_LEN, DATA_W and GAP_CYCLES, plus 1. No wrap during legal operation.

Optional Feature:
- Macro SERIAL_PATTERN_PARITY_EN.
- Defined:
  - PARITY state follows DATA and emits one extra bit = XOR of all DATA_W payload bits (even parity).
  - frame_done moves to the parity-bit cycle.
  - Frame length is SYNC_LEN+DATA_W+1.
- Undefined: no PARITY state; frame ends at data bit 0.

Decomposition:
- Package serial_pattern_pkg: state enum (IDLE, SYNC, DATA, PARITY, GAP), default SYNC_PAT/SYNC_LEN constants shared with the detector side.
- One natural sub-module: piso_shift (parallel-load, MSB-first shift register with load/shift enables, width parameter). Instantiated for the payload; the sync header is indexed by counter.

Test Plan:
- Reset: hold reset=0 for 3 cycles with in_valid=1 → out_bit=0, out_valid=0, frame_done=0, in_ready=0 throughout. Release → in_ready=1 the next cycle.
- Single frame, in_data=8'hA5, defaults → out_bit sequence 1,0,1,0, 1,0,1,0,0,1,0,1 with out_valid=1 for 12 cycles. frame_done high only on the 12th. Then 2 cycles out_valid=0, then in_ready=1.
- Busy ignore: accept 8'h3C, then drive in_valid=1 with 8'hFF for the whole frame → transmitted payload 00111100. Exactly one frame, then 8'hFF accepted only after the gap.
- Abort: accept 8'hF0, assert reset=0 asynchronously during data bit 3 → outputs drop to 0 without waiting for a clock edge. After release, state IDLE and a new frame 8'h0F transmits cleanly.
- GAP_CYCLES=0 back-to-back: in_valid held high with 8'h81 then 8'h7E → 24 contiguous out_valid cycles, two frame_done pulses 12 cycles apart.
- SERIAL_PATTERN_PARITY_EN defined, in_data=8'h07 → 13th bit=1, frame_done on the 13th. With 8'h03 → 13th bit=0.
